// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator with valid/ready request handshake.
// Define PC_RAS_EN to build in the return-address stack for return prediction.
module pc_gen #(
    parameter int                   ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]    RESET_ADDR = '0,
    parameter int                   INST_BYTES = 4,
    parameter int                   RAS_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              stall_i,
    input  logic              req_ready_i,
    input  logic              call_i,
    input  logic              ret_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              req_valid_o,
    output logic              ras_empty_o,
    output logic              ras_full_o
);

    localparam logic [ADDR_W-1:0] INC = ADDR_W'(INST_BYTES);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] ras_top;
    logic              valid_q;
    logic              accept;
    logic              ret_hit;

    assign accept = valid_q & req_ready_i & ~stall_i;
    assign seq_pc = pc_q + INC;

`ifdef PC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  top_idx;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ras_we;
    logic [PTR_W-1:0]  ras_waddr;

    // ptr_q points at the next free slot; a full push lands on the oldest entry.
    assign top_idx = ptr_q - PTR_W'(1);
    assign ras_top = ras_mem[top_idx];
    assign ret_hit = accept & ~jump_flag_i & ret_i & (cnt_q != '0);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        ras_we    = 1'b0;
        ras_waddr = ptr_q;
        if (accept && !jump_flag_i) begin
            if (ret_hit) begin
                if (call_i) begin
                    ras_we    = 1'b1;
                    ras_waddr = top_idx;
                end else begin
                    ptr_d = top_idx;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else if (call_i) begin
                ras_we = 1'b1;
                ptr_d  = ptr_q + PTR_W'(1);
                if (cnt_q != CNT_FULL) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // NOTE: stack storage is left unreset; the count alone says which entries are live.
    always_ff @(posedge clk) begin
        if (ras_we) begin
            ras_mem[ras_waddr] <= seq_pc;
        end
    end

    assign ras_empty_o = (cnt_q == '0);
    assign ras_full_o  = (cnt_q == CNT_FULL);
`else
    logic unused_ras;

    assign ras_top     = '0;
    assign ret_hit     = 1'b0;
    assign ras_empty_o = 1'b1;
    assign ras_full_o  = 1'b0;
    assign unused_ras  = call_i ^ ret_i ^ (RAS_DEPTH > 0);
`endif

    always_comb begin
        pc_d = pc_q;
        if (jump_flag_i) begin
            pc_d = jump_addr_i;
        end else if (ret_hit) begin
            pc_d = ras_top;
        end else if (accept) begin
            pc_d = seq_pc;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_ADDR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= 1'b1;
        end
    end

    assign pc_o        = pc_q;
    assign req_valid_o = valid_q;

endmodule
